inverse_resolver: RTL and testbench



---
 rtl/inverse_resolver_pkg.sv | 22 ++
 rtl/inverse_resolver_datapath.sv | 84 ++++++++
 rtl/inverse_resolver.sv | 97 +++++++++
 tb/tb_inverse_resolver.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/inverse_resolver_pkg.sv
// Shared widths and FSM state encoding for the inverse quadratic resolver.
// Imported by the datapath and the control top.
package inverse_resolver_pkg;

  localparam int XW = 9;
  localparam int CW = 17;
  localparam int HW = CW + XW + 1;
  localparam int PW = CW + 2 * XW + 2;
  localparam int KW = $clog2(XW);

  typedef enum logic [2:0] {
    IDLE,
    H,
    P,
    CMP,
    FIN_H,
    FIN_P,
    FIN_CMP,
    DONE
  } state_t;

endpackage

// File: rtl/inverse_resolver_datapath.sv
// Operand capture, Horner evaluation of p(t), bit-serial x accumulation.
// Strobes come from the control FSM in inverse_resolver.
module inverse_datapath
  import inverse_resolver_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          fin,
  input  logic          h_en,
  input  logic          p_en,
  input  logic          cmp_en,
  input  logic          out_en,
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic [CW-1:0] c,
  input  logic [CW-1:0] y,
  output logic          last,
  output logic          le,
  output logic          eq,
  output logic [XW-1:0] x_out,
  output logic          exact,
  output logic          found
);

  logic [CW-1:0] a_r, b_r, c_r, y_r;
  logic [XW-1:0] x_acc;
  logic [KW-1:0] k;
  logic [HW-1:0] h_reg;
  logic [PW-1:0] p_reg;
  logic [XW-1:0] bit_k;
  logic [XW-1:0] t;
  logic [HW-1:0] h_nxt;
  logic [PW-1:0] p_nxt;

  // Trial value: current prefix with bit k set, or the final prefix itself.
  always_comb begin
    bit_k = XW'(1) << k;
    t     = fin ? x_acc : (x_acc | bit_k);
    h_nxt = HW'(a_r) * HW'(t) + HW'(b_r);
    p_nxt = PW'(h_reg) * PW'(t) + PW'(c_r);
    le    = p_reg <= PW'(y_r);
    eq    = p_reg == PW'(y_r);
    last  = k == '0;
  end

  // Operand capture, Horner steps, accumulation and result latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_r   <= '0;
      b_r   <= '0;
      c_r   <= '0;
      y_r   <= '0;
      x_acc <= '0;
      k     <= KW'(XW - 1);
      h_reg <= '0;
      p_reg <= '0;
      x_out <= '0;
      exact <= 1'b0;
      found <= 1'b0;
    end else begin
      if (load) begin
        a_r   <= a;
        b_r   <= b;
        c_r   <= c;
        y_r   <= y;
        x_acc <= '0;
        k     <= KW'(XW - 1);
      end
      if (h_en) h_reg <= h_nxt;
      if (p_en) p_reg <= p_nxt;
      if (cmp_en) begin
        if (le) x_acc <= x_acc | bit_k;
        if (!last) k <= k - 1'b1;
      end
      if (out_en) begin
        x_out <= x_acc;
        found <= le;
        exact <= eq;
      end
    end
  end

endmodule

// File: rtl/inverse_resolver.sv
// Largest x with a*x^2+b*x+c <= y by MSB-first binary search.
// Control FSM here; arithmetic lives in inverse_datapath.
module inverse_resolver
  import inverse_resolver_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic [CW-1:0] c,
  input  logic [CW-1:0] y,
  output logic [XW-1:0] x_out,
  output logic          exact,
  output logic          found,
  output logic          done
);

  state_t state, nxt;
  logic load, fin, h_en, p_en, cmp_en, out_en;
  logic last, le, eq;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  // Next-state and datapath strobes.
  always_comb begin
    nxt    = state;
    load   = 1'b0;
    fin    = 1'b0;
    h_en   = 1'b0;
    p_en   = 1'b0;
    cmp_en = 1'b0;
    out_en = 1'b0;
    unique case (state)
      IDLE: if (start) begin
        load = 1'b1;
        nxt  = H;
      end
      H: begin
        h_en = 1'b1;
        nxt  = P;
      end
      P: begin
        p_en = 1'b1;
        nxt  = CMP;
      end
      CMP: begin
        cmp_en = 1'b1;
        nxt    = last ? FIN_H : H;
      end
      FIN_H: begin
        fin  = 1'b1;
        h_en = 1'b1;
        nxt  = FIN_P;
      end
      FIN_P: begin
        fin  = 1'b1;
        p_en = 1'b1;
        nxt  = FIN_CMP;
      end
      FIN_CMP: begin
        out_en = 1'b1;
        nxt    = DONE;
      end
      DONE: if (!start) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign done = state == DONE;

  inverse_datapath u_dp (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .fin    (fin),
    .h_en   (h_en),
    .p_en   (p_en),
    .cmp_en (cmp_en),
    .out_en (out_en),
    .a      (a),
    .b      (b),
    .c      (c),
    .y      (y),
    .last   (last),
    .le     (le),
    .eq     (eq),
    .x_out  (x_out),
    .exact  (exact),
    .found  (found)
  );

endmodule

// File: tb/tb_inverse_resolver.sv
// Scoreboard bench: brute-force reference pushes expectations,
// a monitor pops and compares on every rising edge of done.
module tb_inverse_resolver;
  import inverse_resolver_pkg::*;

  typedef struct {
    logic [XW-1:0] x;
    logic          exact;
    logic          found;
    int            e0;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] a = '0, b = '0, c = '0, y = '0;
  logic [XW-1:0] x_out;
  logic          exact, found, done;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic done_q = 1'b0;
  exp_t sb[$];

  inverse_resolver dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .c     (c),
    .y     (y),
    .x_out (x_out),
    .exact (exact),
    .found (found),
    .done  (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t ref_model(longint ra, longint rb,
                                     longint rc, longint ry);
    exp_t   e;
    longint pv;
    e.x = '0;
    e.exact = 1'b0;
    e.found = 1'b0;
    e.e0 = 0;
    for (int x = 0; x < (1 << XW); x++) begin
      pv = ra * x * x + rb * x + rc;
      if (pv <= ry) begin
        e.x = XW'(x);
        e.found = 1'b1;
        e.exact = (pv == ry);
      end
    end
    return e;
  endfunction

  task automatic check(string name, longint act, longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: compare each completed result against the queue head.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (done && !done_q) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done at cycle %0d, expected none",
                 cyc);
      end else begin
        e = sb.pop_front();
        check("x_out", x_out, e.x);
        check("exact", exact, e.exact);
        check("found", found, e.found);
        check("latency", cyc - e0_of(e), 3 * XW + 3);
      end
    end
    done_q = done;
  end

  function automatic int e0_of(exp_t e);
    return e.e0;
  endfunction

  task automatic launch(logic [CW-1:0] ta, logic [CW-1:0] tb,
                        logic [CW-1:0] tc, logic [CW-1:0] ty, bit push);
    exp_t e;
    @(negedge clk);
    a = ta;
    b = tb;
    c = tc;
    y = ty;
    start = 1'b1;
    e = ref_model(ta, tb, tc, ty);
    e.e0 = cyc + 1;
    if (push) sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(bit keep_start);
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #2;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL timeout: got done=0 after 100 cycles, expected 1");
    end
    @(negedge clk);
    start = keep_start;
    if (!keep_start) @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    check("rst_x_out", x_out, 0);
    check("rst_exact", exact, 0);
    check("rst_found", found, 0);
    check("rst_done", done, 0);
    reset = 1'b0;

    launch(2, 1, 3, 39, 1);
    wait_done(0);

    launch(2, 1, 3, 40, 1);
    wait_done(1);
    repeat (5) @(negedge clk);
    check("hold_done", done, 1);
    check("hold_x_out", x_out, 4);
    check("hold_found", found, 1);
    check("hold_exact", exact, 0);
    start = 1'b0;
    @(negedge clk);
    check("release_done", done, 0);

    launch(2, 1, 3, 2, 1);
    wait_done(0);
    launch(0, 0, 0, 0, 1);
    wait_done(0);

    launch(1, 0, 0, 131071, 1);
    repeat (4) @(negedge clk);
    a = 5;
    wait_done(0);

    launch(7, 9, 11, 1000, 0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_done", done, 0);
    check("abort_x_out", x_out, 0);
    check("abort_found", found, 0);
    launch(2, 1, 3, 39, 1);
    wait_done(0);

    for (int i = 0; i < 24; i++) begin
      if (i < 16)
        launch(CW'($urandom_range(0, 15)), CW'($urandom_range(0, 1023)),
               CW'($urandom_range(0, 4095)), CW'($urandom_range(0, 131071)), 1);
      else
        launch(CW'($urandom), CW'($urandom), CW'($urandom), CW'($urandom), 1);
      wait_done(0);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0",
               sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
